// File: rtl/output_serializer.sv
// output_serializer
//   Captures the finished 40-bit results of the left/right ALU pair into a
//   one-deep holding buffer and pulses alu_clear for one cycle. It then shifts
//   both words out MSB first on out_l/out_r under a shared frame strobe. The
//   holding buffer lets the ALUs work on the next sample while the current
//   frame shifts, so frames can run back-to-back.
//
//   Build option: define OUTSER_GAP_EN to insert exactly one idle cycle
//   (out_busy = 0) after every frame.
//
// Ports
//   clk          system clock (SCLK)
//   clear_n      asynchronous active-low reset
//   en           start enable; a frame in progress always completes
//   res_l/res_r  left/right ALU accumulator results
//   valid_l/_r   left/right ALU result-ready levels
//   alu_clear    one-cycle clear pulse to both ALUs on capture
//   out_l/out_r  serial data, MSB first, 0 when not busy
//   out_frame    high while bit WIDTH-1 is presented
//   out_busy     high for all WIDTH bit cycles of a frame
//   frame_count  completed-frame counter, wraps
module output_serializer #(
    parameter int WIDTH = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic [WIDTH-1:0] res_l,
    input  logic [WIDTH-1:0] res_r,
    input  logic             valid_l,
    input  logic             valid_r,
    output logic             alu_clear,
    output logic             out_l,
    output logic             out_r,
    output logic             out_frame,
    output logic             out_busy,
    output logic [CNT_W-1:0] frame_count
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

`ifdef OUTSER_GAP_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] hold_l;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full;
    logic [WIDTH-1:0] sh_l;
    logic [WIDTH-1:0] sh_r;
    logic [BC_W-1:0]  bit_cnt;

    logic frame_end;
    logic drain;
    logic capture;

    always_comb begin
        frame_end = (state == SHIFT) && (bit_cnt == '0);
`ifdef OUTSER_GAP_EN
        // Loading straight out of GAP keeps the inter-frame gap at exactly
        // one cycle; going through IDLE first would make it two.
        drain = hold_full && en && ((state == IDLE) || (state == GAP));
`else
        drain = hold_full && en && ((state == IDLE) || frame_end);
`endif
        // A draining buffer can accept a new word at the same edge.
        capture = valid_l && valid_r && !alu_clear && (!hold_full || drain);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            hold_l      <= '0;
            hold_r      <= '0;
            hold_full   <= 1'b0;
            sh_l        <= '0;
            sh_r        <= '0;
            bit_cnt     <= '0;
            alu_clear   <= 1'b0;
            frame_count <= '0;
        end else begin
            alu_clear <= capture;

            if (capture) begin
                hold_l    <= res_l;
                hold_r    <= res_r;
                hold_full <= 1'b1;
            end else if (drain) begin
                hold_full <= 1'b0;
            end

            if (frame_end) begin
                frame_count <= frame_count + 1'b1;
            end

            if (drain) begin
                sh_l    <= hold_l;
                sh_r    <= hold_r;
                bit_cnt <= LAST_BIT;
                state   <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        sh_l <= {sh_l[WIDTH-2:0], 1'b0};
                        sh_r <= {sh_r[WIDTH-2:0], 1'b0};
                        if (frame_end) begin
`ifdef OUTSER_GAP_EN
                            state <= GAP;
`else
                            state <= IDLE;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
`ifdef OUTSER_GAP_EN
                    GAP: state <= IDLE;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign out_busy  = (state == SHIFT);
    assign out_frame = out_busy && (bit_cnt == LAST_BIT);
    assign out_l     = out_busy ? sh_l[WIDTH-1] : 1'b0;
    assign out_r     = out_busy ? sh_r[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_output_serializer.sv
`timescale 1ns/1ps
module tb_output_serializer;

    localparam int WIDTH = 40;
    localparam int CNT_W = 3;
`ifdef OUTSER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             en = 1'b1;
    logic [WIDTH-1:0] res_l = '0;
    logic [WIDTH-1:0] res_r = '0;
    logic             valid_l = 1'b0;
    logic             valid_r = 1'b0;
    logic             alu_clear;
    logic             out_l;
    logic             out_r;
    logic             out_frame;
    logic             out_busy;
    logic [CNT_W-1:0] frame_count;

    output_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .en          (en),
        .res_l       (res_l),
        .res_r       (res_r),
        .valid_l     (valid_l),
        .valid_r     (valid_r),
        .alu_clear   (alu_clear),
        .out_l       (out_l),
        .out_r       (out_r),
        .out_frame   (out_frame),
        .out_busy    (out_busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
    } frame_t;

    frame_t exp_q[$];
    int     start_cyc[$];
    int     end_cyc[$];
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: assembles each serial frame and compares with the scoreboard.
    initial begin
        logic [WIDTH-1:0] gl;
        logic [WIDTH-1:0] gr;
        int               idx;
        logic             collecting;
        frame_t           e;
        gl = '0; gr = '0; idx = 0; collecting = 1'b0;
        forever begin
            @(negedge clk);
            if (!clear_n) begin
                collecting = 1'b0;
                idx = 0;
            end else begin
                if (out_frame) begin
                    if (collecting) check("frame_short", idx, WIDTH);
                    collecting = 1'b1;
                    idx = 0;
                    start_cyc.push_back(cyc);
                end
                if (out_busy) begin
                    if (!collecting) check("busy_without_frame", collecting, 1);
                    gl = {gl[WIDTH-2:0], out_l};
                    gr = {gr[WIDTH-2:0], out_r};
                    idx++;
                    if (idx == WIDTH) begin
                        end_cyc.push_back(cyc);
                        collecting = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_l", gl, e.l);
                            check("frame_r", gr, e.r);
                        end
                    end
                end else if (collecting) begin
                    check("busy_dropped", idx, WIDTH);
                    collecting = 1'b0;
                end
            end
        end
    end

    // ALU model: holds both valids until alu_clear is seen, then drops them.
    task automatic issue(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                         input int budget, output int waited, output int cap_cyc);
        frame_t f;
        f.l = l;
        f.r = r;
        exp_q.push_back(f);
        res_l = l;
        res_r = r;
        valid_l = 1'b1;
        valid_r = 1'b1;
        waited = 0;
        cap_cyc = -1;
        while (waited < budget) begin
            @(posedge clk); #1;
            waited++;
            if (alu_clear) begin
                cap_cyc = cyc;
                break;
            end
        end
        valid_l = 1'b0;
        valid_r = 1'b0;
        check("capture_seen", alu_clear, 1);
        if (cap_cyc >= 0) begin
            @(posedge clk); #1;
            check("alu_clear_pulse", alu_clear, 0);
        end
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (start_cyc.size() < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("frame_started", start_cyc.size(), n);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (end_cyc.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("frames_done", end_cyc.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   c0, c1, ca, cb, cc, cd, ce, cg, cf;
        int   ke;
        logic saw;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_clear", alu_clear, 0);
        check("rst_out_l", out_l, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_frame", out_frame, 0);
        check("rst_out_busy", out_busy, 0);
        check("rst_frame_count", frame_count, 0);
        clear_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frame
        issue(40'h80_0000_0001, 40'h00_0000_0002, 10, w, c0);
        check("single_wait", w, 1);
        wait_frames(1, 100);
        check("single_latency", start_cyc[0], c0 + 1);
        check("single_length", end_cyc[0] - start_cyc[0], WIDTH - 1);
        check("count_1", frame_count, 1);

        // Unequal valids: nothing captured until both are high
        res_l = 40'h5A_A5F0_0F3C;
        res_r = 40'hC3_3C96_6901;
        valid_l = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            saw = saw | alu_clear | out_busy;
        end
        check("unequal_idle", saw, 0);
        issue(40'h5A_A5F0_0F3C, 40'hC3_3C96_6901, 10, w, c1);
        check("unequal_wait", w, 1);
        wait_frames(2, 100);
        check("count_2", frame_count, 2);

        // Back-to-back, then stall on a full holding buffer
        issue(40'h12_3456_789A, 40'hFE_DCBA_9876, 10, w, ca);
        wait_starts(3);
        repeat (5) @(posedge clk);
        #1;
        issue(40'hAA_AAAA_AAAA, 40'h55_5555_5555, 10, w, cb);
        check("b2b_immediate", w, 1);
        issue(40'h00_FF00_FF01, 40'hF0_0F0F_00F1, 200, w, cc);
        check("stall_capture", cc, end_cyc[2] + 1 + GAP);
        wait_frames(5, 300);
        check("b2b_abut", start_cyc[3], end_cyc[2] + 1 + GAP);
        check("stall_abut", start_cyc[4], end_cyc[3] + 1 + GAP);
        check("count_5", frame_count, 5);

        // Enable low: running frame completes, next load deferred
        issue(40'h01_0203_0405, 40'h80_4020_1008, 10, w, cd);
        wait_starts(6);
        en = 1'b0;
        issue(40'hDE_ADBE_EF00, 40'h0B_ADC0_FFEE, 10, w, ce);
        check("en_low_capture", w, 1);
        wait_frames(6, 100);
        repeat (10) @(posedge clk);
        #1;
        check("en_low_idle", out_busy, 0);
        check("en_low_deferred", start_cyc.size(), 6);
        en = 1'b1;
        ke = cyc;
        wait_frames(7, 100);
        check("en_load", start_cyc[6], ke + 1);
        check("count_7", frame_count, 7);

        // Counter wrap
        issue(40'h7F_FFFF_FFFE, 40'h80_0000_0000, 10, w, cg);
        wait_frames(8, 100);
        check("count_wrap", frame_count, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset mid-frame
        issue(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 10, w, cf);
        wait_starts(9);
        repeat (19) @(posedge clk);
        #2;
        check("pre_reset_busy", out_busy, 1);
        check("pre_reset_out_l", out_l, 1);
        clear_n = 1'b0;
        #1;
        check("mid_rst_out_l", out_l, 0);
        check("mid_rst_out_r", out_r, 0);
        check("mid_rst_out_frame", out_frame, 0);
        check("mid_rst_out_busy", out_busy, 0);
        check("mid_rst_frame_count", frame_count, 0);
        check("mid_rst_alu_clear", alu_clear, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        clear_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("no_residual", start_cyc.size(), 9);
        check("count_after_reset", frame_count, 0);
        check("idle_after_reset", out_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
